// File: rtl/gshare_predictor.sv
// Global-history branch direction predictor: saturating counters indexed by PC xor a speculative GHR,
// with a one-cycle registered prediction and checkpoint-based GHR recovery on mispredict.
module gshare_predictor #(
  parameter int INDEX_WIDTH   = 6,
  parameter int HISTORY_WIDTH = 6,
  parameter int COUNTER_WIDTH = 2,
  parameter int USE_GSHARE    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     query,
  input  logic [31:0]              query_pc,
  output logic                     predict_valid,
  output logic                     predict_result,
  output logic [INDEX_WIDTH-1:0]   predict_index,
  output logic [HISTORY_WIDTH-1:0] predict_history,
  input  logic                     update,
  input  logic [INDEX_WIDTH-1:0]   update_index,
  input  logic                     update_result,
  input  logic                     update_mispredict,
  input  logic [HISTORY_WIDTH-1:0] update_history
);

  localparam int ENTRIES = 1 << INDEX_WIDTH;
  localparam logic [COUNTER_WIDTH-1:0] INIT =
    (COUNTER_WIDTH == 1) ? '0 : COUNTER_WIDTH'((1 << (COUNTER_WIDTH - 1)) - 1);

  logic [COUNTER_WIDTH-1:0] counters [ENTRIES];
  logic [HISTORY_WIDTH-1:0] ghr;

  logic [INDEX_WIDTH-1:0]   pc_bits;
  logic [INDEX_WIDTH-1:0]   query_idx;
  logic [COUNTER_WIDTH-1:0] query_ctr;
  logic                     pred_bit;
  logic                     recover;
  logic                     accept;
  logic                     unused_bits;

  function automatic logic [COUNTER_WIDTH-1:0] sat_step(
    input logic [COUNTER_WIDTH-1:0] c,
    input logic                     up
  );
    if (up) return (&c) ? c : c + COUNTER_WIDTH'(1);
    else    return (|c) ? c - COUNTER_WIDTH'(1) : c;
  endfunction

  // Truncating cast drops the oldest bit; also covers the single-bit history case.
  function automatic logic [HISTORY_WIDTH-1:0] shift_hist(
    input logic [HISTORY_WIDTH-1:0] h,
    input logic                     b
  );
    return HISTORY_WIDTH'({h, b});
  endfunction

  assign pc_bits   = query_pc[INDEX_WIDTH:1];
  assign query_idx = (USE_GSHARE != 0) ? (pc_bits ^ INDEX_WIDTH'(ghr)) : pc_bits;
  assign query_ctr = counters[query_idx];
  assign pred_bit  = query_ctr[COUNTER_WIDTH-1];
  assign recover   = update & update_mispredict;
  assign accept    = query & ~recover;

  assign unused_bits = ^{query_pc[31:INDEX_WIDTH+1], query_pc[0], update_history[HISTORY_WIDTH-1]};

  // Stage boundary: table read at query -> registered prediction outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) counters[i] <= INIT;
      ghr             <= '0;
      predict_valid   <= 1'b0;
      predict_result  <= 1'b0;
      predict_index   <= '0;
      predict_history <= '0;
    end else if (rdy) begin
      if (update) counters[update_index] <= sat_step(counters[update_index], update_result);
      if (recover)     ghr <= shift_hist(update_history, update_result);
      else if (accept) ghr <= shift_hist(ghr, pred_bit);
      predict_valid <= accept;
      if (accept) begin
        predict_result  <= pred_bit;
        predict_index   <= query_idx;
        predict_history <= ghr;
      end
    end
  end

endmodule

// File: doc/gshare_predictor.md
# gshare_predictor

Parametrised global-history branch direction predictor for the instruction-fetch stage, replacing the fixed 16-entry, 2-bit, PC-indexed predictor. It holds a table of saturating counters indexed by PC bits XOR a speculative global history register (GHR). Each prediction is returned with the table index and a history checkpoint, which the fetch unit carries with the branch. On resolution the commit side writes the counter and, on a mispredict, restores the GHR from the checkpoint.

## Interface
- INDEX_WIDTH, 6, table has 2^INDEX_WIDTH counters; index base is pc[INDEX_WIDTH:1]
- HISTORY_WIDTH, 6, GHR length; legal range 1..INDEX_WIDTH
- COUNTER_WIDTH, 2, saturating counter width; legal range 1..4
- USE_GSHARE, 1, 1 = index is pc bits XOR zero-extended GHR; 0 = bimodal (GHR still maintained, not used in the index)

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global enable; low freezes all state and outputs
- query  in  1  prediction request
- query_pc  in  32  branch PC
- predict_valid  out  1  one-cycle pulse, response to an accepted query
- predict_result  out  1  1 = predict taken
- predict_index  out  INDEX_WIDTH  table index used; returned on update
- predict_history  out  HISTORY_WIDTH  GHR value before this prediction was shifted in
- update  in  1  branch resolved
- update_index  in  INDEX_WIDTH  index captured from predict_index
- update_result  in  1  actual outcome, 1 = taken
- update_mispredict  in  1  predicted direction was wrong
- update_history  in  HISTORY_WIDTH  checkpoint captured from predict_history

## Operation
- Table entries are unsigned COUNTER_WIDTH-bit values. The prediction is taken when the counter MSB is 1. INIT = 2^(COUNTER_WIDTH-1)-1 (weakly not-taken); INIT = 0 when COUNTER_WIDTH = 1.
- Query index: idx = query_pc[INDEX_WIDTH:1] ^ {zeros, ghr} when USE_GSHARE = 1, otherwise query_pc[INDEX_WIDTH:1].
- Accepted query (rdy & query & !(update & update_mispredict)):
  - predict_result <= MSB(table[idx])
  - predict_index <= idx
  - predict_history <= ghr
  - ghr <= {ghr[HISTORY_WIDTH-2:0], predicted bit}, or ghr <= predicted bit when HISTORY_WIDTH = 1
  - predict_valid <= 1
- Otherwise, while rdy is high, predict_valid <= 0. The other predict_* outputs hold their values.
- Update (rdy & update): table[update_index] increments when update_result = 1, saturating at 2^COUNTER_WIDTH-1. It decrements when update_result = 0, saturating at 0.
- Mispredict (update & update_mispredict): ghr <= {update_history[HISTORY_WIDTH-2:0], update_result}. A query in the same cycle is dropped (predict_valid <= 0, GHR not shifted), because fetch is being redirected.
- Correct-prediction updates do not touch the GHR.
- Same-cycle query and update to the same index: the query reads the pre-update counter, and the update still commits.
- rdy low: no table write, no GHR change, and all outputs hold, including predict_valid.

## Timing
- Prediction latency is 1 cycle: a query sampled at edge N produces registered outputs valid after edge N.
- Back-to-back queries are accepted every cycle. Each query sees the GHR already shifted by every earlier accepted query.
- A table update is visible to queries from the cycle after it is sampled.
- Recovered GHR is used by a query sampled on the next edge.
- Reset (takes effect regardless of rdy):
  - all counters = INIT, ghr = 0
  - predict_valid = 0, predict_result = 0, predict_index = 0, predict_history = 0
  - A query or update in the reset cycle is discarded.
- Reset mid-stream: the cycle after reset behaves as a cold start. In-flight checkpoints are not special-cased.

## Test plan
- Reset then query pc=0x100 -> predict_valid=1 one cycle later, predict_result=0, predict_index=0x00, predict_history=0; GHR becomes 0.
- Default parameters, two taken updates at index 5 -> counter 1->2->3. A query mapping to index 5 with GHR=0 then predicts 1. Two further taken updates keep the counter at 3, and three not-taken updates give 2, 1, 0 (saturation at both ends).
- Queries predicted taken, taken, not-taken from GHR=0 -> predict_history sequence 0x00, 0x01, 0x03 and GHR=0x06. The index XOR is checked against a model.
- Mispredict update with update_history=0x05, update_result=1, and a concurrent query -> query dropped (predict_valid=0), GHR=0x0B; the next query reports predict_history=0x0B.
- Query and update to the same index in one cycle with counter=1 and a taken update -> prediction 0, and a following query predicts 1. Holding rdy low for 3 cycles with query and update asserted leaves the table, GHR and outputs unchanged.
- USE_GSHARE=0, COUNTER_WIDTH=3, INDEX_WIDTH=4 -> index = pc[4:1] regardless of GHR, INIT=3, taken threshold 4, saturation at 7.
